// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB that allocates tags, captures CDB results and retires in order
// Ports:
//   clk, reset                      clock (rising edge), synchronous active-high reset
//   dispatch_valid/dest/ready       allocation handshake; accepted iff valid && ready
//   assign_tag                      tag the next allocation will receive (tail pointer)
//   cdb_valid/tag/value             result broadcast captured into the matching live entry
//   rd1_tag/rd1_value, rd2_*        operand lookup of stored entry values (0 if not live)
//   flush                           squash every entry, overriding all other activity
//   commit_valid/reg_addr/rob_tag/value  head retirement toward map table and regfile
//   count                           number of occupied entries
module reorder_buffer #(
  parameter int ROB_TAG_LEN  = 3,
  parameter int REG_ADDR_LEN = 5,
  parameter int XLEN         = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dispatch_valid,
  input  logic [REG_ADDR_LEN-1:0] dispatch_dest,
  output logic                    dispatch_ready,
  output logic [ROB_TAG_LEN-1:0]  assign_tag,
  input  logic                    cdb_valid,
  input  logic [ROB_TAG_LEN-1:0]  cdb_tag,
  input  logic [XLEN-1:0]         cdb_value,
  input  logic [ROB_TAG_LEN-1:0]  rd1_tag,
  input  logic [ROB_TAG_LEN-1:0]  rd2_tag,
  output logic [XLEN-1:0]         rd1_value,
  output logic [XLEN-1:0]         rd2_value,
  input  logic                    flush,
  output logic                    commit_valid,
  output logic [REG_ADDR_LEN-1:0] commit_reg_addr,
  output logic [ROB_TAG_LEN-1:0]  commit_rob_tag,
  output logic [XLEN-1:0]         commit_value,
  output logic [ROB_TAG_LEN-1:0]  count
);
  // The all-ones tag is reserved as the map table's "no tag" value, so one slot is sacrificed.
  localparam int DEPTH = 2**ROB_TAG_LEN - 1;
  localparam logic [ROB_TAG_LEN-1:0] LAST = ROB_TAG_LEN'(DEPTH - 1);
  localparam logic [ROB_TAG_LEN-1:0] FULL = ROB_TAG_LEN'(DEPTH);
  localparam logic [ROB_TAG_LEN-1:0] SENT = '1;
  logic [DEPTH-1:0]        ent_valid, ent_ready;
  logic [REG_ADDR_LEN-1:0] ent_dest  [DEPTH];
  logic [XLEN-1:0]         ent_value [DEPTH];
  logic [ROB_TAG_LEN-1:0]  head, tail;
  logic                    alloc, cdb_hit;
  function automatic logic [ROB_TAG_LEN-1:0] nxt(input logic [ROB_TAG_LEN-1:0] p);
    return p == LAST ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    dispatch_ready  = count != FULL;
    assign_tag      = tail;
    alloc           = dispatch_valid && dispatch_ready && !flush;
    // The tail slot is never live, so a CDB hit and an allocation can't collide.
    cdb_hit         = cdb_valid && cdb_tag != SENT && ent_valid[cdb_tag] && !flush;
    commit_valid    = ent_valid[head] && ent_ready[head] && !flush;
    commit_reg_addr = commit_valid ? ent_dest[head] : '0;
    commit_rob_tag  = commit_valid ? head : '0;
    commit_value    = commit_valid ? ent_value[head] : '0;
    // No CDB bypass: a value is visible only once it has been written into the entry.
    rd1_value       = (rd1_tag != SENT && ent_valid[rd1_tag]) ? ent_value[rd1_tag] : '0;
    rd2_value       = (rd2_tag != SENT && ent_valid[rd2_tag]) ? ent_value[rd2_tag] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ent_valid <= '0;
      ent_ready <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (commit_valid) begin
        ent_valid[head] <= 1'b0;
        head            <= nxt(head);
      end
      if (cdb_hit) begin
        ent_ready[cdb_tag] <= 1'b1;
        ent_value[cdb_tag] <= cdb_value;
      end
      if (alloc) begin
        ent_valid[tail] <= 1'b1;
        ent_ready[tail] <= 1'b0;
        ent_dest[tail]  <= dispatch_dest;
        ent_value[tail] <= '0;
        tail            <= nxt(tail);
      end
      count <= count + ROB_TAG_LEN'(alloc) - ROB_TAG_LEN'(commit_valid);
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and randomized checks of reorder_buffer against a queue-based model
module tb_reorder_buffer;
  logic        clk = 0, reset = 1;
  logic        dispatch_valid = 0, dispatch_ready, cdb_valid = 0, flush = 0, commit_valid;
  logic [4:0]  dispatch_dest = 0, commit_reg_addr;
  logic [2:0]  assign_tag, cdb_tag = 0, rd1_tag = 7, rd2_tag = 7, commit_rob_tag, count;
  logic [31:0] cdb_value = 0, rd1_value, rd2_value, commit_value;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  reorder_buffer dut (
    .clk(clk), .reset(reset), .dispatch_valid(dispatch_valid), .dispatch_dest(dispatch_dest),
    .dispatch_ready(dispatch_ready), .assign_tag(assign_tag), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_value(cdb_value), .rd1_tag(rd1_tag), .rd2_tag(rd2_tag),
    .rd1_value(rd1_value), .rd2_value(rd2_value), .flush(flush), .commit_valid(commit_valid),
    .commit_reg_addr(commit_reg_addr), .commit_rob_tag(commit_rob_tag),
    .commit_value(commit_value), .count(count));
  // Reference model: live entries in program order, oldest first.
  typedef struct {logic [2:0] tag; logic [4:0] dest; bit rdy; logic [31:0] val;} ent_t;
  ent_t q[$];
  logic [2:0] m_tail = 0;
  bit m_com, m_al;
  function automatic bit m_cv();
    return q.size() > 0 && q[0].rdy && !flush;
  endfunction
  function automatic logic [4:0] m_creg();
    if (m_cv()) return q[0].dest;
    return 0;
  endfunction
  function automatic logic [2:0] m_ctag();
    if (m_cv()) return q[0].tag;
    return 0;
  endfunction
  function automatic logic [31:0] m_cval();
    if (m_cv()) return q[0].val;
    return 0;
  endfunction
  function automatic logic [31:0] m_rd(input logic [2:0] t);
    foreach (q[i]) if (q[i].tag == t) return q[i].val;
    return 0;
  endfunction
  always @(posedge clk) begin
    if (reset || flush) begin
      q.delete();
      m_tail = 0;
    end else begin
      m_com = m_cv();
      m_al  = dispatch_valid && q.size() != 7;
      if (cdb_valid) foreach (q[i]) if (q[i].tag == cdb_tag) begin q[i].rdy = 1; q[i].val = cdb_value; end
      if (m_com) void'(q.pop_front());
      if (m_al) begin
        q.push_back('{m_tail, dispatch_dest, 1'b0, 32'd0});
        m_tail = m_tail == 6 ? 3'd0 : m_tail + 3'd1;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle();
    dispatch_valid = 0; cdb_valid = 0; flush = 0;
  endtask
  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
  endtask
  task automatic test_reset();
    idle(); reset = 1; tick(); tick(); #1;
    checks++; if (dispatch_ready !== 1) begin errors++; $display("FAIL reset_ready: got %0h want 1", dispatch_ready); end
    checks++; if (assign_tag !== 0) begin errors++; $display("FAIL reset_tag: got %0h want 0", assign_tag); end
    checks++; if (commit_valid !== 0) begin errors++; $display("FAIL reset_cv: got %0h want 0", commit_valid); end
    checks++; if ({commit_reg_addr, commit_rob_tag, commit_value} !== 0) begin errors++; $display("FAIL reset_commit_fields: got %0h/%0h/%0h want 0", commit_reg_addr, commit_rob_tag, commit_value); end
    checks++; if (count !== 0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    reset = 0;
  endtask
  task automatic test_fill();
    for (int i = 0; i < 7; i++) begin
      dispatch_valid = 1; dispatch_dest = 5'(i + 1); #1;
      checks++; if (assign_tag !== 3'(i) || dispatch_ready !== 1) begin errors++; $display("FAIL fill_tag%0d: got tag %0d ready %0h want tag %0d ready 1", i, assign_tag, dispatch_ready, i); end
      tick();
    end
    dispatch_dest = 9; #1;
    checks++; if (count !== 7 || dispatch_ready !== 0) begin errors++; $display("FAIL fill_full: got count %0d ready %0h want 7/0", count, dispatch_ready); end
    tick(); dispatch_valid = 0; #1;
    checks++; if (count !== 7 || assign_tag !== 0) begin errors++; $display("FAIL fill_overflow: got count %0d tag %0d want 7/0", count, assign_tag); end
  endtask
  task automatic test_in_order();
    cdb_valid = 1; cdb_tag = 2; cdb_value = 32'hAA; #1;
    checks++; if (commit_valid !== 0) begin errors++; $display("FAIL order_nocommit0: got %0h want 0", commit_valid); end
    tick(); cdb_tag = 0; cdb_value = 32'h11; rd1_tag = 2; #1;
    checks++; if (commit_valid !== 0) begin errors++; $display("FAIL order_tag2_blocked: got %0h want 0", commit_valid); end
    checks++; if (rd1_value !== 32'hAA) begin errors++; $display("FAIL order_rd_tag2: got %0h want aa", rd1_value); end
    tick(); cdb_valid = 0; #1;
    checks++; if ({commit_valid, commit_reg_addr, commit_rob_tag, commit_value} !== {1'b1, 5'd1, 3'd0, 32'h11}) begin errors++; $display("FAIL order_commit0: got %0h/%0h/%0h/%0h want 1/1/0/11", commit_valid, commit_reg_addr, commit_rob_tag, commit_value); end
    tick(); #1;
    checks++; if (commit_valid !== 0 || count !== 6) begin errors++; $display("FAIL order_wait_tag1: got cv %0h count %0d want 0/6", commit_valid, count); end
    cdb_valid = 1; cdb_tag = 1; cdb_value = 32'h22; tick(); cdb_valid = 0; #1;
    checks++; if ({commit_valid, commit_reg_addr, commit_rob_tag, commit_value} !== {1'b1, 5'd2, 3'd1, 32'h22}) begin errors++; $display("FAIL order_commit1: got %0h/%0h/%0h/%0h want 1/2/1/22", commit_valid, commit_reg_addr, commit_rob_tag, commit_value); end
    tick(); #1;
    checks++; if ({commit_valid, commit_reg_addr, commit_rob_tag, commit_value} !== {1'b1, 5'd3, 3'd2, 32'hAA}) begin errors++; $display("FAIL order_commit2: got %0h/%0h/%0h/%0h want 1/3/2/aa", commit_valid, commit_reg_addr, commit_rob_tag, commit_value); end
    tick(); #1;
    checks++; if (commit_valid !== 0 || count !== 4) begin errors++; $display("FAIL order_after: got cv %0h count %0d want 0/4", commit_valid, count); end
  endtask
  task automatic test_full_commit();
    do_reset();
    for (int i = 0; i < 7; i++) begin dispatch_valid = 1; dispatch_dest = 5'(i + 1); tick(); end
    dispatch_valid = 0; cdb_valid = 1; cdb_tag = 0; cdb_value = 32'h55; tick();
    cdb_valid = 0; dispatch_valid = 1; dispatch_dest = 8; #1;
    checks++; if (commit_valid !== 1 || dispatch_ready !== 0 || count !== 7) begin errors++; $display("FAIL full_commit_cycle: got cv %0h ready %0h count %0d want 1/0/7", commit_valid, dispatch_ready, count); end
    tick(); #1;
    checks++; if (count !== 6 || dispatch_ready !== 1 || assign_tag !== 0) begin errors++; $display("FAIL full_after_commit: got count %0d ready %0h tag %0d want 6/1/0", count, dispatch_ready, assign_tag); end
    tick(); dispatch_valid = 0; #1;
    checks++; if (count !== 7 || assign_tag !== 1) begin errors++; $display("FAIL full_wrap_alloc: got count %0d tag %0d want 7/1", count, assign_tag); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin dispatch_valid = 1; dispatch_dest = 5'(i + 1); tick(); end
    dispatch_valid = 0; cdb_valid = 1; cdb_tag = 0; cdb_value = 32'h10; tick();
    dispatch_valid = 1; dispatch_dest = 4; cdb_tag = 1; cdb_value = 32'h20; #1;
    checks++; if (commit_valid !== 1 || commit_rob_tag !== 0 || count !== 3) begin errors++; $display("FAIL b2b_cycle: got cv %0h tag %0d count %0d want 1/0/3", commit_valid, commit_rob_tag, count); end
    tick(); idle(); #1;
    checks++; if (count !== 3 || assign_tag !== 4) begin errors++; $display("FAIL b2b_ptrs: got count %0d tag %0d want 3/4", count, assign_tag); end
    checks++; if ({commit_valid, commit_rob_tag, commit_value} !== {1'b1, 3'd1, 32'h20}) begin errors++; $display("FAIL b2b_next_commit: got %0h/%0h/%0h want 1/1/20", commit_valid, commit_rob_tag, commit_value); end
  endtask
  task automatic test_ignored();
    tick();
    cdb_valid = 1; cdb_tag = 7; cdb_value = 32'hDEAD; rd1_tag = 7; rd2_tag = 2; #1;
    checks++; if (rd1_value !== 0 || rd2_value !== 0) begin errors++; $display("FAIL ign_rd: got %0h/%0h want 0/0", rd1_value, rd2_value); end
    tick(); cdb_tag = 0; cdb_value = 32'hBEEF; #1;
    checks++; if (commit_valid !== 0 || count !== 2) begin errors++; $display("FAIL ign_sentinel: got cv %0h count %0d want 0/2", commit_valid, count); end
    tick(); idle(); rd1_tag = 0; #1;
    checks++; if (commit_valid !== 0 || rd1_value !== 0 || count !== 2) begin errors++; $display("FAIL ign_freed: got cv %0h rd %0h count %0d want 0/0/2", commit_valid, rd1_value, count); end
  endtask
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin dispatch_valid = 1; dispatch_dest = 5'(i + 1); tick(); end
    dispatch_valid = 0; cdb_valid = 1; cdb_tag = 0; cdb_value = 32'h77; tick();
    flush = 1; dispatch_valid = 1; cdb_tag = 1; #1;
    checks++; if (commit_valid !== 0 || commit_value !== 0) begin errors++; $display("FAIL flush_cycle: got cv %0h val %0h want 0/0", commit_valid, commit_value); end
    tick(); idle(); rd1_tag = 1; #1;
    checks++; if (count !== 0 || assign_tag !== 0 || dispatch_ready !== 1 || rd1_value !== 0) begin errors++; $display("FAIL flush_after: got count %0d tag %0d ready %0h rd %0h want 0/0/1/0", count, assign_tag, dispatch_ready, rd1_value); end
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      dispatch_valid = 1'($urandom_range(0, 2) != 0); dispatch_dest = 5'($urandom);
      cdb_valid = 1'($urandom); cdb_tag = 3'($urandom); cdb_value = $urandom;
      rd1_tag = 3'($urandom); rd2_tag = 3'($urandom); flush = $urandom_range(0, 59) == 0;
      #1;
      checks++; if (dispatch_ready !== (q.size() != 7) || assign_tag !== m_tail || count !== 3'(q.size())) begin errors++; $display("FAIL rand_alloc c%0d: got ready %0h tag %0d count %0d want %0h/%0d/%0d", c, dispatch_ready, assign_tag, count, q.size() != 7, m_tail, q.size()); end
      checks++; if ({commit_valid, commit_reg_addr, commit_rob_tag, commit_value} !== {m_cv(), m_creg(), m_ctag(), m_cval()}) begin errors++; $display("FAIL rand_commit c%0d: got %0h/%0h/%0h/%0h want %0h/%0h/%0h/%0h", c, commit_valid, commit_reg_addr, commit_rob_tag, commit_value, m_cv(), m_creg(), m_ctag(), m_cval()); end
      checks++; if (rd1_value !== m_rd(rd1_tag) || rd2_value !== m_rd(rd2_tag)) begin errors++; $display("FAIL rand_rd c%0d: got %0h/%0h want %0h/%0h", c, rd1_value, rd2_value, m_rd(rd1_tag), m_rd(rd2_tag)); end
      tick();
    end
    idle(); reset = 1; tick(); reset = 0; #1;
    checks++; if (count !== 0 || commit_valid !== 0 || assign_tag !== 0) begin errors++; $display("FAIL rand_midreset: got count %0d cv %0h tag %0d want 0/0/0", count, commit_valid, assign_tag); end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_in_order();
    test_full_commit();
    test_back_to_back();
    test_ignored();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
